dmem_lsu: RTL and testbench

Load/store access unit sitting directly upstream of the 1024x32 word-only data RAM (data_array). It converts RV32 LB/LH/LW/LBU/LHU/SB/SH/SW requests from the execute/memory stage into word accesses on the RAM port.
- Loads: aligned and sign/zero-extended.
- Sub-word stores: read-modify-write, because the RAM has only a single whole-word write mask.
- Misaligned or illegal requests are rejected with an error response and make no RAM access.

---
 rtl/dmem_lsu_pkg.sv | 35 +++
 rtl/dmem_lsu_align.sv | 44 ++++
 rtl/dmem_lsu.sv | 148 ++++++++++++++
 tb/tb_dmem_lsu.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_lsu_pkg.sv
// Shared definitions for the data-memory load/store unit: RV32 funct3 width
// codes, the FSM state encoding and the request legality rule.
package dmem_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        LD_WAIT = 2'b01,
        RMW_WR  = 2'b10,
        RESP    = 2'b11
    } lsu_state_t;

    // 1 when the request is misaligned or uses an illegal funct3.
    // Unsigned widths only exist for loads, so a store with BU/HU is illegal.
    function automatic logic req_error(input logic we,
                                       input logic [2:0] funct3,
                                       input logic [1:0] byte_off);
        logic err;
        case (funct3)
            F3_B:    err = 1'b0;
            F3_H:    err = byte_off[0];
            F3_W:    err = (byte_off != 2'b00);
            F3_BU:   err = we;
            F3_HU:   err = we | byte_off[0];
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/dmem_lsu_align.sv
// Purely combinational lane logic: load extract/extend and store lane merge.
// Kept separate so the cache path can reuse it unchanged.
module lsu_align
    import dmem_lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  byte_off,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    // Select the addressed byte/half of the fetched word and extend it.
    always_comb begin
        lane_byte = rdata[{byte_off, 3'b000} +: 8];
        lane_half = byte_off[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_B:    load_data = {{24{lane_byte[7]}}, lane_byte};
            F3_BU:   load_data = {24'h000000, lane_byte};
            F3_H:    load_data = {{16{lane_half[15]}}, lane_half};
            F3_HU:   load_data = {16'h0000, lane_half};
            default: load_data = rdata;
        endcase
    end

    // Overlay the low byte/half of the store data onto the old word at the lane.
    always_comb begin
        merge_data = rdata;
        case (funct3)
            F3_B: merge_data[{byte_off, 3'b000} +: 8] = wdata[7:0];
            F3_H: begin
                if (byte_off[1]) merge_data[31:16] = wdata[15:0];
                else             merge_data[15:0]  = wdata[15:0];
            end
            F3_W:    merge_data = wdata;
            default: merge_data = rdata;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit in front of the word-only data RAM. Sub-word stores are
// done as read-modify-write since the RAM has a single whole-word write mask.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | ready; RAM access for the incoming request issued this cycle
// LD_WAIT | read data on mem_rdata; extract/extend into resp_rdata
// RMW_WR  | old word on mem_rdata; write back the merged word
// RESP    | one-cycle response pulse, not ready
module dmem_lsu
    import dmem_lsu_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_en,
    output logic              mem_wmode,
    output logic              mem_wmask,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    lsu_state_t        state, state_next;
    logic [2:0]        funct3_q;
    logic [1:0]        off_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic              err_q;
    logic              accept;
    logic              req_err;
    logic [31:0]       load_data;
    logic [31:0]       merge_data;
    logic              unused_addr_hi;

    // Byte address bits above the RAM word index wrap and are ignored.
    assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

    assign req_ready  = (state == IDLE);
    assign accept     = req_valid && req_ready;
    assign req_err    = req_error(req_we, req_funct3, req_addr[1:0]);
    assign resp_valid = (state == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    lsu_align u_align (
        .funct3     (funct3_q),
        .byte_off   (off_q),
        .rdata      (mem_rdata),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Capture request fields at acceptance for use in later states.
    always_ff @(posedge clk) begin
        if (rst) begin
            funct3_q <= F3_B;
            off_q    <= 2'b00;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else if (accept) begin
            funct3_q <= req_funct3;
            off_q    <= req_addr[1:0];
            waddr_q  <= req_addr[ADDR_W+1:2];
            wdata_q  <= req_wdata;
        end
    end

    // Response data/error: cleared on accept (stores and errors return 0),
    // filled with the extended load value in LD_WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            rdata_q <= '0;
            err_q   <= req_err;
        end else if (state == LD_WAIT) begin
            rdata_q <= load_data;
        end
    end

    // Next-state and RAM port drive; reset always masks the RAM enable so an
    // RMW interrupted by reset never writes.
    always_comb begin
        state_next = state;
        mem_en     = 1'b0;
        mem_wmode  = 1'b0;
        mem_wmask  = 1'b0;
        mem_addr   = req_addr[ADDR_W+1:2];
        mem_wdata  = req_wdata;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_err) begin
                        state_next = RESP;
                    end else if (!req_we) begin
                        mem_en     = 1'b1;
                        state_next = LD_WAIT;
                    end else if (req_funct3 == F3_W) begin
                        mem_en     = 1'b1;
                        mem_wmode  = 1'b1;
                        mem_wmask  = 1'b1;
                        state_next = RESP;
                    end else begin
                        mem_en     = 1'b1;
                        state_next = RMW_WR;
                    end
                end
            end
            LD_WAIT: state_next = RESP;
            RMW_WR: begin
                mem_en     = 1'b1;
                mem_wmode  = 1'b1;
                mem_wmask  = 1'b1;
                mem_addr   = waddr_q;
                mem_wdata  = merge_data;
                state_next = RESP;
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (rst) begin
            mem_en    = 1'b0;
            mem_wmode = 1'b0;
            mem_wmask = 1'b0;
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: a behavioural RAM on the memory port,
// directed scenarios plus random traffic checked against a byte-level model.
module tb_dmem_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_en;
    logic        mem_wmode;
    logic        mem_wmask;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;

    logic [31:0] ram [0:1023];
    logic [31:0] ref_mem [0:1023];
    logic        pre_we = 1'b0;
    logic [9:0]  pre_addr = '0;
    logic [31:0] pre_data = '0;
    int          en_cnt = 0;
    int          wr_cnt = 0;
    logic [31:0] last_wr = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_lsu #(.ADDR_W(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_en     (mem_en),
        .mem_wmode  (mem_wmode),
        .mem_wmask  (mem_wmask),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Word RAM with registered read; also counts enables and writes.
    always @(posedge clk) begin
        if (pre_we) begin
            ram[pre_addr] <= pre_data;
        end else if (mem_en) begin
            en_cnt <= en_cnt + 1;
            if (mem_wmode && mem_wmask) begin
                ram[mem_addr] <= mem_wdata;
                wr_cnt        <= wr_cnt + 1;
                last_wr       <= mem_wdata;
            end else begin
                mem_rdata <= ram[mem_addr];
            end
        end
    end

    task automatic preload(input logic [9:0] a, input logic [31:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clk);
        #1 pre_we = 1'b0;
        ref_mem[a] = d;
    endtask

    // Reference: request semantics in terms of bytes and plain arithmetic.
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] rd, output logic er,
                         output int lat, output int nen, output int nwr);
        int          w, off, size;
        bit          sgn, known;
        logic [31:0] mask, v;
        w = int'((addr >> 2) % 1024);
        off = int'(addr % 4);
        known = 1'b1; sgn = 1'b1; size = 1;
        case (f3)
            3'd0: begin size = 1; sgn = 1'b1; end
            3'd1: begin size = 2; sgn = 1'b1; end
            3'd2: begin size = 4; sgn = 1'b1; end
            3'd4: begin size = 1; sgn = 1'b0; end
            3'd5: begin size = 2; sgn = 1'b0; end
            default: known = 1'b0;
        endcase
        mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
        rd = '0; er = 1'b0; lat = 0; nen = 0; nwr = 0;
        if (!known || (off % size) != 0 || (we && !sgn)) begin
            er = 1'b1; lat = 1;
        end else if (!we) begin
            v = (ref_mem[w] >> (8 * off)) & mask;
            if (sgn && size < 4 && v >= (32'd1 << (8 * size - 1)))
                v = v - (32'd1 << (8 * size));
            rd = v; lat = 2; nen = 1;
        end else begin
            ref_mem[w] = (ref_mem[w] & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
            lat = (size == 4) ? 1 : 2;
            nen = (size == 4) ? 1 : 2;
            nwr = 1;
        end
    endtask

    // Issue one request and collect what the DUT did; no checking here.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, output logic [31:0] rd, output logic er,
                          output int lat, output logic en0, output logic wm0,
                          output logic [9:0] a0, output int den, output int dwr,
                          output logic post_ok);
        int en_s, wr_s;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        #1;
        en0 = mem_en; wm0 = mem_wmode; a0 = mem_addr;
        en_s = en_cnt; wr_s = wr_cnt;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 99; rd = '0; er = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat = i; rd = resp_rdata; er = resp_err;
                break;
            end
        end
        @(negedge clk);
        post_ok = !resp_valid && req_ready;
        den = en_cnt - en_s;
        dwr = wr_cnt - wr_s;
    endtask

    task automatic test_reset();
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h14;
        #1;
        checks++;
        if (mem_en !== 1'b0) begin
            errors++; $display("FAIL reset_mem_en got %b want 0", mem_en);
        end
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({resp_valid, resp_err, req_ready, mem_en, mem_wmode, mem_wmask} !== 6'b001000) begin
            errors++;
            $display("FAIL reset_state got v%b e%b rdy%b en%b wm%b mk%b want v0 e0 rdy1 en0 wm0 mk0",
                     resp_valid, resp_err, req_ready, mem_en, mem_wmode, mem_wmask);
        end
        checks++;
        if (resp_rdata !== 32'h0) begin
            errors++; $display("FAIL reset_rdata got %h want 00000000", resp_rdata);
        end
    endtask

    task automatic test_load();
        logic [31:0] rd; logic er, en0, wm0, pok; logic [9:0] a0; int lat, den, dwr;
        logic [2:0]  f3s  [5] = '{3'd2, 3'd0, 3'd4, 3'd1, 3'd5};
        logic [31:0] adrs [5] = '{32'h14, 32'h17, 32'h17, 32'h16, 32'h14};
        logic [31:0] exps [5] = '{32'hDEADBEEF, 32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000BEEF};
        preload(10'd5, 32'hDEADBEEF);
        for (int i = 0; i < 5; i++) begin
            do_req(1'b0, f3s[i], adrs[i], 32'h0, rd, er, lat, en0, wm0, a0, den, dwr, pok);
            checks++;
            if (rd !== exps[i] || er !== 1'b0) begin
                errors++; $display("FAIL load_%0d_data got %h err %b want %h err 0", i, rd, er, exps[i]);
            end
            checks++;
            if (lat != 2 || en0 !== 1'b1 || wm0 !== 1'b0 || a0 !== 10'd5 || den != 1 || dwr != 0 || !pok) begin
                errors++;
                $display("FAIL load_%0d_timing got lat %0d en %b wm %b addr %0d en_n %0d wr_n %0d post %b want 2 1 0 5 1 0 1",
                         i, lat, en0, wm0, a0, den, dwr, pok);
            end
        end
    endtask

    task automatic test_store();
        logic [31:0] rd; logic er, en0, wm0, pok; logic [9:0] a0; int lat, den, dwr;
        preload(10'd2, 32'h11223344);
        do_req(1'b1, 3'd0, 32'h09, 32'h000000AB, rd, er, lat, en0, wm0, a0, den, dwr, pok);
        checks++;
        if (lat != 2 || en0 !== 1'b1 || wm0 !== 1'b0 || a0 !== 10'd2 || den != 2 || dwr != 1 || er !== 1'b0 || rd !== 32'h0) begin
            errors++;
            $display("FAIL sb_rmw got lat %0d en %b wm %b addr %0d en_n %0d wr_n %0d err %b rd %h want 2 1 0 2 2 1 0 0",
                     lat, en0, wm0, a0, den, dwr, er, rd);
        end
        checks++;
        if (last_wr !== 32'h1122AB44) begin
            errors++; $display("FAIL sb_write_data got %h want 1122ab44", last_wr);
        end
        do_req(1'b0, 3'd2, 32'h08, 32'h0, rd, er, lat, en0, wm0, a0, den, dwr, pok);
        checks++;
        if (rd !== 32'h1122AB44) begin
            errors++; $display("FAIL sb_readback got %h want 1122ab44", rd);
        end
        do_req(1'b1, 3'd2, 32'h0C, 32'hCAFEF00D, rd, er, lat, en0, wm0, a0, den, dwr, pok);
        checks++;
        if (lat != 1 || en0 !== 1'b1 || wm0 !== 1'b1 || a0 !== 10'd3 || den != 1 || dwr != 1 || !pok) begin
            errors++;
            $display("FAIL sw got lat %0d en %b wm %b addr %0d en_n %0d wr_n %0d post %b want 1 1 1 3 1 1 1",
                     lat, en0, wm0, a0, den, dwr, pok);
        end
        do_req(1'b1, 3'd1, 32'h0E, 32'h00001234, rd, er, lat, en0, wm0, a0, den, dwr, pok);
        do_req(1'b0, 3'd2, 32'h0C, 32'h0, rd, er, lat, en0, wm0, a0, den, dwr, pok);
        checks++;
        if (rd !== 32'h1234F00D) begin
            errors++; $display("FAIL sh_readback got %h want 1234f00d", rd);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er, en0, wm0, pok; logic [9:0] a0; int lat, den, dwr;
        logic        wes  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [2:0]  f3s  [5] = '{3'd2, 3'd1, 3'd3, 3'd4, 3'd7};
        logic [31:0] adrs [5] = '{32'h02, 32'h01, 32'h10, 32'h10, 32'h10};
        for (int i = 0; i < 5; i++) begin
            do_req(wes[i], f3s[i], adrs[i], 32'hFFFF_FFFF, rd, er, lat, en0, wm0, a0, den, dwr, pok);
            checks++;
            if (er !== 1'b1 || rd !== 32'h0 || lat != 1 || en0 !== 1'b0 || den != 0 || !pok) begin
                errors++;
                $display("FAIL err_%0d got err %b rd %h lat %0d en %b en_n %0d post %b want 1 0 1 0 0 1",
                         i, er, rd, lat, en0, den, pok);
            end
        end
    endtask

    task automatic test_reset_mid_rmw();
        logic [31:0] rd; logic er, en0, wm0, pok; logic [9:0] a0; int lat, den, dwr;
        int  wr_s;
        bit  saw_valid;
        preload(10'd3, 32'hA5A5A5A5);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h0D; req_wdata = 32'h77;
        @(posedge clk);
        #1 req_valid = 1'b0;
        wr_s = wr_cnt;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (mem_en !== 1'b0) begin
            errors++; $display("FAIL rst_rmw_mem_en got %b want 0", mem_en);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        saw_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (resp_valid) saw_valid = 1'b1;
        end
        checks++;
        if (saw_valid || req_ready !== 1'b1 || wr_cnt != wr_s) begin
            errors++;
            $display("FAIL rst_rmw_abort got resp_seen %b ready %b writes %0d want 0 1 0",
                     saw_valid, req_ready, wr_cnt - wr_s);
        end
        do_req(1'b0, 3'd2, 32'h0C, 32'h0, rd, er, lat, en0, wm0, a0, den, dwr, pok);
        checks++;
        if (rd !== 32'hA5A5A5A5) begin
            errors++; $display("FAIL rst_rmw_word got %h want a5a5a5a5", rd);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, erd, addr, wd; logic er, eer, en0, wm0, pok, we; logic [9:0] a0;
        logic [2:0]  f3;
        int lat, den, dwr, elat, enen, enwr, bad_words;
        for (int i = 0; i < 32; i++) preload(10'(i), $urandom);
        for (int n = 0; n < 200; n++) begin
            we   = 1'($urandom_range(0, 1));
            f3   = 3'($urandom_range(0, 7));
            addr = {22'($urandom), 10'($urandom_range(0, 7)), 2'($urandom_range(0, 3))} >> 2;
            addr = ($urandom & 32'hFFFF_F000) | (addr & 32'h0000_0FFF);
            addr = (addr & 32'hFFFF_F003) | (32'($urandom_range(0, 31)) << 2);
            wd   = $urandom;
            model(we, f3, addr, wd, erd, eer, elat, enen, enwr);
            do_req(we, f3, addr, wd, rd, er, lat, en0, wm0, a0, den, dwr, pok);
            checks++;
            if (rd !== erd || er !== eer || lat != elat || !pok) begin
                errors++;
                $display("FAIL rand_%0d_resp we %b f3 %0d addr %h got rd %h err %b lat %0d post %b want %h %b %0d 1",
                         n, we, f3, addr, rd, er, lat, pok, erd, eer, elat);
            end
            checks++;
            if (den != enen || dwr != enwr || en0 !== (eer ? 1'b0 : 1'b1) ||
                (!eer && (a0 !== addr[11:2] || wm0 !== (we && f3 == 3'd2)))) begin
                errors++;
                $display("FAIL rand_%0d_ram we %b f3 %0d got en_n %0d wr_n %0d en %b wm %b addr %0d want %0d %0d",
                         n, we, f3, den, dwr, en0, wm0, a0, enen, enwr);
            end
        end
        bad_words = 0;
        for (int i = 0; i < 32; i++) if (ram[i] !== ref_mem[i]) bad_words++;
        checks++;
        if (bad_words != 0) begin
            errors++; $display("FAIL rand_ram_image got %0d differing words want 0", bad_words);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        test_load();
        test_store();
        test_errors();
        test_reset_mid_rmw();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
